alu_md: RTL and testbench
=========================

# alu_md

Multi-cycle, parametrised successor to the single-cycle integer ALU in the RISC-V datapath. It keeps the base logic/arithmetic operations (one-cycle registered result) and adds the full RV32M multiply/divide set, implemented as an iterative shift-add multiplier and restoring divider. A valid/ready handshake on input and output lets the execute stage stall on long operations.

## Interface
- XLEN, 32: operand/result width; must be ≥ 8 and even.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands and ALUsel valid
- in_ready  out  1  block can accept an operation
- reg1  in  XLEN  operand A (rs1)
- reg2  in  XLEN  operand B (rs2 / immediate)
- ALUsel  in  5  operation select
- out_valid  out  1  ALUresult valid, held until out_ready
- out_ready  in  1  consumer takes result
- ALUresult  out  XLEN  registered result
- busy  out  1  high in CALC state

## Operation
- ALUsel[4]=0 (base, 1-cycle): 00000 AND; 00001 OR; 00010 ADD; 00011 {reg2[XLEN-13:0], 12'b0}; 00110 SUB; 00111 SLTU (unsigned less-than, result 1/0); 01000 SLT (signed); 01100 NOR. Add/sub wrap modulo 2^XLEN.
- ALUsel[4]=1, ALUsel[3]=0, ALUsel[2:0]=funct3: 000 MUL (low XLEN), 001 MULH (s×s high), 010 MULHSU (reg1 signed × reg2 unsigned, high), 011 MULHU (u×u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Any other ALUsel: accepted, ALUresult=0 after one cycle.
- Signed mul/div: operands converted to magnitude at accept; unsigned core runs; result negated in final CALC cycle per RISC-V rules (product sign = XOR of operand signs; quotient sign likewise; remainder takes dividend sign).
- Divide by zero: quotient = all ones, remainder = reg1. Signed overflow (reg1 = -2^(XLEN-1), reg2 = -1): quotient = reg1, remainder = 0. Both detected at accept; no CALC.
- FSM states IDLE, CALC, DONE:
  - IDLE: in_ready=1. On in_valid: base op / undefined / div special case → result registered, DONE; mul/div → load operands, counter=XLEN-1, CALC.
  - CALC: one product/quotient bit per cycle; counter decrements; at counter=0 apply sign fixup, DONE.
  - DONE: out_valid=1, ALUresult stable; on out_ready → IDLE. No new accept in the same cycle as the output handshake.
- Inputs ignored outside IDLE; operands captured at accept, so reg1/reg2/ALUsel may change afterwards.

## Timing
- Reset (rst high at edge): state=IDLE, out_valid=0, ALUresult=0, busy=0, internal counter/accumulators=0; in_ready=0 while rst is high, 1 in the first cycle after release.
- Reset mid-CALC or in DONE: operation and pending result discarded, no out_valid.
- Accept at edge N (in_valid & in_ready). Base op / special divide: out_valid from N+1. Mul/div: busy N+1..N+XLEN, out_valid from N+XLEN+1 (latency XLEN+1, 33 at default).
- out_valid held, ALUresult unchanged, while out_ready=0 (indefinite stall allowed). Handshake at edge M → out_valid=0 and in_ready=1 from M+1; minimum initiation interval 2 cycles for base ops.
- out_ready high before out_valid has no effect.

## Test plan
- Base ops, XLEN=32: reg1=0xFFFF0000, reg2=0x0000FFFF through AND/OR/ADD/SUB/NOR → 0x0, 0xFFFFFFFF, 0xFFFFFFFF, 0xFFFE0001, 0x0, each out_valid exactly one cycle after accept.
- SLT vs SLTU: reg1=0xFFFFFFFF, reg2=1 → SLT=1, SLTU=0; LUI-shift reg2=0x00012345 → 0x12345000.
- Multiply: reg1=0xFFFFFFFF (-1), reg2=2 → MUL=0xFFFFFFFE, MULH=0xFFFFFFFF, MULHSU=0xFFFFFFFF, MULHU=0x00000001; out_valid at accept+33, busy high 32 cycles.
- Divide: -7 / 2 → DIV=0xFFFFFFFD, REM=0xFFFFFFFF; DIVU 7/0 → 0xFFFFFFFF, REMU 7/0 → 7, both after 1 cycle; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0.
- Backpressure: out_ready low 10 cycles after MUL completes → out_valid and ALUresult stable, in_ready=0, new in_valid ignored; out_ready high → in_ready=1 next cycle.
- Reset mid-operation: assert rst at accept+10 of DIVU → next cycle out_valid=0, ALUresult=0, busy=0; in_ready=1 the cycle after rst drops; following ADD 3+4 returns 7.

Source files
------------

// File: rtl/alu_md.sv
// Multi-cycle RV32-style ALU: one-cycle base operations plus the RV32M
// multiply/divide set on an iterative shift-add / restoring-divide core.
module alu_md #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] reg1,
    input  logic [XLEN-1:0] reg2,
    input  logic [4:0]      ALUsel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALUresult,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [2:0]      op_q, op_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [XLEN:0]     mul_sum_s;
    logic [XLEN:0]     div_sh_s;
    logic [XLEN:0]     div_diff_s;
    logic [XLEN-1:0]   step_hi_s;
    logic [XLEN-1:0]   step_lo_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   final_s;
    logic              signed_div_s;
    logic              mul_sa_s;
    logic              mul_sb_s;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic is_signed);
        if (is_signed && v[XLEN-1]) begin
            mag = -v;
        end else begin
            mag = v;
        end
    endfunction

    function automatic logic [XLEN-1:0] base_op(input logic [4:0] sel,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        case (sel)
            5'b00000: base_op = a & b;
            5'b00001: base_op = a | b;
            5'b00010: base_op = a + b;
            5'b00011: base_op = b << 12;
            5'b00110: base_op = a - b;
            5'b00111: base_op = (a < b) ? ONE : ZERO;
            5'b01000: base_op = ($signed(a) < $signed(b)) ? ONE : ZERO;
            5'b01100: base_op = ~(a | b);
            default:  base_op = ZERO;
        endcase
    endfunction

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_CALC);
    assign ALUresult = result_q;

    // One iteration of the shared core; hi holds partial product / remainder, lo the multiplier / quotient.
    always_comb begin
        mul_sum_s  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
        div_sh_s   = {hi_q, lo_q[XLEN-1]};
        div_diff_s = div_sh_s - {1'b0, opb_q};
        if (op_q[2]) begin
            if (!div_diff_s[XLEN]) begin
                step_hi_s = div_diff_s[XLEN-1:0];
                step_lo_s = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                step_hi_s = div_sh_s[XLEN-1:0];
                step_lo_s = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            step_hi_s = mul_sum_s[XLEN:1];
            step_lo_s = {mul_sum_s[0], lo_q[XLEN-1:1]};
        end
        prod_s = neg_res_q ? -{step_hi_s, step_lo_s} : {step_hi_s, step_lo_s};
        quo_s  = neg_res_q ? -step_lo_s : step_lo_s;
        rem_s  = neg_rem_q ? -step_hi_s : step_hi_s;
        if (op_q[2]) begin
            final_s = op_q[1] ? rem_s : quo_s;
        end else if (op_q == 3'b000) begin
            final_s = prod_s[XLEN-1:0];
        end else begin
            final_s = prod_s[2*XLEN-1:XLEN];
        end
    end

    // Next-state, operand capture and result selection.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        opb_d        = opb_q;
        op_d         = op_q;
        neg_res_d    = neg_res_q;
        neg_rem_d    = neg_rem_q;
        result_d     = result_q;
        signed_div_s = ~ALUsel[0];
        mul_sa_s     = (ALUsel[2:0] == 3'b001) || (ALUsel[2:0] == 3'b010);
        mul_sb_s     = (ALUsel[2:0] == 3'b001);
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (ALUsel[4:3] == 2'b10) begin
                        op_d = ALUsel[2:0];
                        if (ALUsel[2]) begin
                            // Divide-by-zero and signed overflow resolve immediately.
                            if (reg2 == ZERO) begin
                                result_d = ALUsel[1] ? reg1 : ALL_ONES;
                                state_d  = S_DONE;
                            end else if (signed_div_s && (reg1 == MIN_NEG) && (reg2 == ALL_ONES)) begin
                                result_d = ALUsel[1] ? ZERO : reg1;
                                state_d  = S_DONE;
                            end else begin
                                neg_res_d = signed_div_s & (reg1[XLEN-1] ^ reg2[XLEN-1]);
                                neg_rem_d = signed_div_s & reg1[XLEN-1];
                                lo_d      = mag(reg1, signed_div_s);
                                opb_d     = mag(reg2, signed_div_s);
                                hi_d      = ZERO;
                                cnt_d     = CW'(XLEN - 1);
                                state_d   = S_CALC;
                            end
                        end else begin
                            neg_res_d = (mul_sa_s & reg1[XLEN-1]) ^ (mul_sb_s & reg2[XLEN-1]);
                            neg_rem_d = 1'b0;
                            opb_d     = mag(reg1, mul_sa_s);
                            lo_d      = mag(reg2, mul_sb_s);
                            hi_d      = ZERO;
                            cnt_d     = CW'(XLEN - 1);
                            state_d   = S_CALC;
                        end
                    end else begin
                        result_d = base_op(ALUsel, reg1, reg2);
                        state_d  = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                hi_d = step_hi_s;
                lo_d = step_lo_s;
                if (cnt_q == {CW{1'b0}}) begin
                    result_d = final_s;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CW{1'b0}};
            hi_q      <= ZERO;
            lo_q      <= ZERO;
            opb_q     <= ZERO;
            op_q      <= 3'b000;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= ZERO;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opb_q     <= opb_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_md.sv
// Directed self-checking bench for alu_md at XLEN=32.
module tb_alu_md;

    localparam logic [4:0] OP_AND    = 5'b00000;
    localparam logic [4:0] OP_OR     = 5'b00001;
    localparam logic [4:0] OP_ADD    = 5'b00010;
    localparam logic [4:0] OP_LUI    = 5'b00011;
    localparam logic [4:0] OP_SUB    = 5'b00110;
    localparam logic [4:0] OP_SLTU   = 5'b00111;
    localparam logic [4:0] OP_SLT    = 5'b01000;
    localparam logic [4:0] OP_NOR    = 5'b01100;
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  ALUsel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUresult;
    logic        busy;

    int n_checks;
    int n_errors;

    alu_md #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .reg1      (reg1),
        .reg2      (reg2),
        .ALUsel    (ALUsel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUresult (ALUresult),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one operation, measure latency and busy cycles, check result, then drain it.
    task automatic run_op(input string tag, input logic [4:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        int busy_n;
        check_eq({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        ALUsel   = sel;
        reg1     = a;
        reg2     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reg1     = 32'hDEAD_BEEF;
        reg2     = 32'h1234_5678;
        ALUsel   = OP_ADD;
        lat      = 1;
        busy_n   = busy ? 1 : 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat    = lat + 1;
            busy_n = busy_n + (busy ? 1 : 0);
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat - 1));
        check_eq({tag, "_result"}, ALUresult, exp);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_out_valid_drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int lat;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reg1      = 32'd0;
        reg2      = 32'd0;
        ALUsel    = 5'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_result", ALUresult, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("rel_in_ready", {31'd0, in_ready}, 32'd1);

        run_op("and",  OP_AND, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 1);
        run_op("or",   OP_OR,  32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF, 1);
        run_op("add",  OP_ADD, 32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF, 1);
        run_op("sub",  OP_SUB, 32'hFFFF0000, 32'h0000FFFF, 32'hFFFE0001, 1);
        run_op("nor",  OP_NOR, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 1);
        run_op("addw", OP_ADD, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1);
        run_op("slt",  OP_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1);
        run_op("sltu", OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1);
        run_op("lui",  OP_LUI, 32'h0, 32'h00012345, 32'h12345000, 1);
        run_op("undef4",  5'b00100, 32'h5, 32'h3, 32'h00000000, 1);
        run_op("undef24", 5'b11000, 32'h5, 32'h3, 32'h00000000, 1);

        run_op("mul",    OP_MUL,    32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 33);
        run_op("mulh",   OP_MULH,   32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 33);
        run_op("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 33);
        run_op("mulhu",  OP_MULHU,  32'hFFFFFFFF, 32'h2, 32'h00000001, 33);
        run_op("mul2",   OP_MUL,    32'd12345, 32'd6789, 32'h04FED79D, 33);

        run_op("div",   OP_DIV,  32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 33);
        run_op("rem",   OP_REM,  32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 33);
        run_op("div_pn", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        run_op("rem_pn", OP_REM, 32'd7, 32'hFFFFFFFE, 32'h00000001, 33);
        run_op("divu",  OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu",  OP_REMU, 32'd100, 32'd7, 32'd2, 33);
        run_op("divu0", OP_DIVU, 32'd7, 32'd0, 32'hFFFFFFFF, 1);
        run_op("remu0", OP_REMU, 32'd7, 32'd0, 32'd7, 1);
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

        // Backpressure: hold the MUL result while a new request is offered.
        ALUsel   = OP_MUL;
        reg1     = 32'hFFFFFFFF;
        reg2     = 32'h2;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat = lat + 1;
        end
        check_eq("bp_latency", 32'(lat), 32'd33);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            ALUsel   = OP_ADD;
            reg1     = 32'd1;
            reg2     = 32'd1;
            @(posedge clk);
            #1;
            check_eq("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check_eq("bp_result", ALUresult, 32'hFFFFFFFE);
            check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check_eq("bp_release_ready", {31'd0, in_ready}, 32'd1);
        check_eq("bp_release_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of a DIVU.
        ALUsel   = OP_DIVU;
        reg1     = 32'd1000;
        reg2     = 32'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check_eq("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_result", ALUresult, 32'd0);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rel_ready", {31'd0, in_ready}, 32'd1);
        check_eq("mid_rel_valid", {31'd0, out_valid}, 32'd0);
        run_op("post_rst_add", OP_ADD, 32'd3, 32'd4, 32'd7, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
